// File: rtl/mp3_pkg.sv
// mp3_pkg: shared types and constants for the MP3 stream feeder
package mp3_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_DREQ, BURST, DRAIN} feeder_state_t;
  localparam int DEF_BURST_WORDS = 16;
  localparam int DREQ_SYNC_STAGES = 2;
  localparam bit SPI_MSB_FIRST = 1'b1;
endpackage

// File: rtl/mp3_word_fifo.sv
// mp3_word_fifo: synchronous FIFO with a registered show-ahead output and total occupancy count
module mp3_word_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd,
  output logic [W-1:0]  o_rdata,
  output logic          o_rvalid,
  output logic [CW-1:0] o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_scnt;
  logic [W-1:0] r_out;
  logic r_ov;
  logic w_free, w_sread, w_bypass, w_swrite;
  assign w_free = !r_ov | i_rd;
  assign w_sread = w_free & (r_scnt != '0);
  assign w_bypass = w_free & i_wr & (r_scnt == '0);
  assign w_swrite = i_wr & !w_bypass;
  assign o_rdata = r_out;
  assign o_rvalid = r_ov;
  assign o_count = r_scnt + CW'(r_ov);
  // storage array; pointers qualify its contents so it needs no reset
  always_ff @(posedge clk)
    if (w_swrite) r_mem[r_wp] <= i_wdata;
  // pointers, storage occupancy and the output register (fed straight from the write port when storage is empty)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_scnt <= '0;
      r_out <= '0;
      r_ov <= 1'b0;
    end else begin
      r_wp <= r_wp + PW'(w_swrite);
      r_rp <= r_rp + PW'(w_sread);
      r_scnt <= r_scnt + CW'(w_swrite) - CW'(w_sread);
      if (w_sread) r_out <= r_mem[r_rp];
      else if (w_bypass) r_out <= i_wdata;
      if (w_free) r_ov <= w_sread | w_bypass;
    end
endmodule

// File: rtl/mp3_stream_feeder.sv
// mp3_stream_feeder: DREQ-gated burst fetcher from song memory to the SPI stage
module mp3_stream_feeder
  import mp3_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int unsigned SONG_WORDS = 4096,
  parameter int BURST_WORDS = DEF_BURST_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic              i_DREQ,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [15:0]       i_mem_data,
  output logic [15:0]       o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);
  localparam int AW = ADDR_W + 1;
  localparam int BW = $clog2(BURST_WORDS + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] SONG_END = AW'(SONG_WORDS);
  localparam logic [AW-1:0] BURST_LEN = AW'(BURST_WORDS);
  feeder_state_t r_state, w_next;
  logic [DREQ_SYNC_STAGES-1:0] r_dreq;
  logic [AW-1:0] r_addr, w_rem;
  logic [BW-1:0] r_cnt;
  logic r_inflight, r_stop, r_done;
  logic w_dreq_s, w_end, w_drained, w_issue, w_load, w_clr, w_done, w_pop;
  logic [CW-1:0] w_fcount;
  logic [15:0] w_word;
  assign w_dreq_s = r_dreq[DREQ_SYNC_STAGES-1];
  assign w_rem = SONG_END - r_addr;
  assign w_end = r_addr == SONG_END;
  assign w_drained = (w_fcount == '0) & !r_inflight;
  assign w_issue = (r_state == BURST) & (r_cnt != '0) & ((w_fcount + CW'(r_inflight)) < CW'(FIFO_DEPTH));
  assign w_pop = o_valid & i_ready;
  assign o_mem_addr = r_addr[ADDR_W-1:0];
  assign o_mem_rd = w_issue;
  assign o_busy = r_state != IDLE;
  assign o_done = r_done;
  assign o_data = SPI_MSB_FIRST ? w_word : {w_word[7:0], w_word[15:8]};
  mp3_word_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_wr(r_inflight),
    .i_wdata(i_mem_data),
    .i_rd(w_pop),
    .o_rdata(w_word),
    .o_rvalid(o_valid),
    .o_count(w_fcount)
  );
  // two-flop synchronizer for the decoder request line
  always_ff @(posedge clk or posedge rst)
    if (rst) r_dreq <= '0;
    else r_dreq <= {r_dreq[DREQ_SYNC_STAGES-2:0], i_DREQ};
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // FSM next state and datapath controls; a burst only ends once every word has left on o_valid
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_clr = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = i_start & !i_stop;
        w_next = w_clr ? WAIT_DREQ : IDLE;
      end
      WAIT_DREQ: begin
        w_load = !r_stop & w_dreq_s;
        w_next = r_stop ? IDLE : w_dreq_s ? BURST : WAIT_DREQ;
      end
      BURST: w_next = (r_cnt == '0) ? DRAIN : BURST;
      DRAIN: if (w_drained) begin
        w_clr = !r_stop & w_end & i_loop;
        w_done = !r_stop & w_end & !i_loop;
        w_next = (r_stop | w_done) ? IDLE : WAIT_DREQ;
      end
      default: w_next = IDLE;
    endcase
  end
  // address pointer, burst counter, read-in-flight tracking, sticky stop and done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      r_cnt <= '0;
      r_inflight <= 1'b0;
      r_stop <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_addr <= w_clr ? '0 : r_addr + AW'(w_issue);
      r_cnt <= w_load ? ((w_rem < BURST_LEN) ? w_rem[BW-1:0] : BW'(BURST_WORDS)) : r_cnt - BW'(w_issue);
      r_inflight <= w_issue;
      r_stop <= (w_next == IDLE) ? 1'b0 : r_stop | (i_stop & (r_state != IDLE));
      r_done <= w_done;
    end
endmodule

// File: doc/mp3_stream_feeder.md
# mp3_stream_feeder

Upstream data source for the MP3 decoder SPI stage. Fetches 16-bit audio words from a synchronous song memory, buffers them, and hands them to the SPI serializer over a valid/ready handshake. Transfers run in DREQ-gated bursts: the decoder's request line must be high before each 32-byte burst starts. Handles playback start, stop at a burst boundary, optional looping, and an end-of-song pulse.

## Interface
- ADDR_W, 16, song memory word-address width
- SONG_WORDS, 16'd4096, song length in 16-bit words (≥1, ≤2^ADDR_W)
- BURST_WORDS, 16, words per DREQ-gated burst (32 bytes)
- FIFO_DEPTH, 4, internal word buffer depth (power of 2, ≥2)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse; begin playback at address 0
- i_stop  in  1  one-cycle pulse; end playback at next burst boundary
- i_loop  in  1  1 = wrap to address 0 at song end instead of finishing
- i_DREQ  in  1  decoder data request (asynchronous to clk)
- o_mem_addr  out  ADDR_W  song memory read address
- o_mem_rd  out  1  read strobe; i_mem_data valid exactly 1 cycle later
- i_mem_data  in  16  memory read data
- o_data  out  16  word to SPI stage; [15:8] is sent first
- o_valid  out  1  o_data valid
- i_ready  in  1  SPI stage accepts word when o_valid & i_ready
- o_busy  out  1  high from start acceptance until return to IDLE
- o_done  out  1  one-cycle pulse at natural song end (not on stop)

## Operation
- i_DREQ goes through a 2-flop synchronizer; all decisions use the synchronized value dreq_s.
- States: IDLE, WAIT_DREQ, BURST, DRAIN.
- IDLE: on i_start → WAIT_DREQ; address pointer and burst counter cleared. i_start outside IDLE is ignored. If i_start and i_stop arrive together in IDLE, stay in IDLE.
- WAIT_DREQ: if a stop is pending → IDLE. Otherwise, when dreq_s = 1 → BURST with burst counter = min(BURST_WORDS, SONG_WORDS − addr).
- BURST: issue one read per cycle while words remain and (fifo_count + reads_in_flight) < FIFO_DEPTH. Each read increments the address and decrements the counter. Returned data is written to the FIFO one cycle after its o_mem_rd. When the counter reaches 0 → DRAIN.
- DRAIN: wait until the FIFO is empty, no reads are in flight and no word is pending on o_valid. Then:
  - stop pending → IDLE
  - else if addr == SONG_WORDS: if i_loop = 1, addr ← 0 and → WAIT_DREQ; otherwise pulse o_done and → IDLE
  - else → WAIT_DREQ
- DREQ falling mid-burst does not abort the burst; the decoder guarantees 32 bytes of space whenever DREQ is high.
- i_stop while busy sets a sticky stop_pending flag, cleared on entry to IDLE. A burst is never truncated, so the SPI stage always sees whole bursts.
- Handshake: once o_valid rises, o_data stays stable and o_valid stays high until accepted. No word is dropped or duplicated. Output order equals memory address order.
- o_busy = (state != IDLE).

## Timing
- All outputs reset to 0: o_mem_addr, o_mem_rd, o_data, o_valid, o_busy, o_done.
- i_start at cycle N → o_busy = 1 at N+1.
- With i_DREQ held high at least 2 cycles beforehand, the first o_mem_rd occurs at N+2.
- Read-to-output latency: o_mem_rd at cycle M → word on o_data with o_valid at M+2 (FIFO has a registered output), provided the FIFO ahead of it is empty.
- Throughput: 1 word/cycle sustained when i_ready is held high.
- Burst-to-burst gap: DRAIN exit + WAIT_DREQ evaluation is at least 1 cycle after the last handshake.
- Reset asserted mid-burst: all state clears immediately and asynchronously. In-flight read data is discarded.

## Structure
- Shared package mp3_pkg holds:
  - the feeder state enum
  - the default BURST_WORDS constant (16)
  - DREQ_SYNC_STAGES = 2
  - the SPI byte-order constant (MSB byte first)
- Sub-module mp3_word_fifo: synchronous FIFO, parameterised width/depth, with count output and registered read data. The feeder FSM, read scheduler and DREQ synchronizer live in mp3_stream_feeder.

## Test plan
- Basic play: SONG_WORDS=40, memory[k]=k, DREQ high, i_ready high, i_start → 40 handshakes carrying 0..39 in order; bursts of 16, 16, 8; o_done pulses once; o_busy falls.
- DREQ gating: DREQ low after the first burst → no o_mem_rd while low. DREQ high → next burst starts at address 16 within 3 cycles.
- Backpressure: i_ready toggled pseudo-randomly → o_data stable while o_valid & !i_ready; never more than FIFO_DEPTH words outstanding; sequence intact.
- Stop mid-burst: i_stop at word 5 of burst 1 → all 16 words of the burst delivered, then IDLE; no o_done; next i_start restarts at address 0.
- Loop: i_loop=1, SONG_WORDS=20 → word stream 0..19, 0..19, …; no o_done until i_loop is cleared.
- Async reset at the cycle o_mem_rd is high → all outputs 0 immediately; after release, idle until i_start.
